// File: rtl/udp_tx_framer_if.sv
// Signal bundle between the UDP transmit framer and its environment:
// frame request, FWFT payload source, byte stream to the RMII serializer, and status.
interface udp_tx_framer_if;
  // Byte stream: a byte moves on any clock where tx_byte_valid && tx_byte_ready.
  // While valid is high and ready is low, tx_byte holds its value. Valid does not
  // depend on ready. payload_ready marks the clock in which payload_data is taken.
  logic        tx_start;
  logic [10:0] tx_len;
  logic [47:0] dest_mac;
  logic [31:0] dest_ip;
  logic [15:0] dest_port;
  logic [7:0]  payload_data;
  logic        payload_ready;
  logic [7:0]  tx_byte;
  logic        tx_byte_valid;
  logic        tx_byte_ready;
  logic        tx_busy;
  logic        tx_done;
  logic        tx_err;
  logic [3:0]  dbg_state;

  modport master (
    input  tx_start, tx_len, dest_mac, dest_ip, dest_port, payload_data, tx_byte_ready,
    output payload_ready, tx_byte, tx_byte_valid, tx_busy, tx_done, tx_err, dbg_state
  );

  modport slave (
    output tx_start, tx_len, dest_mac, dest_ip, dest_port, payload_data, tx_byte_ready,
    input  payload_ready, tx_byte, tx_byte_valid, tx_busy, tx_done, tx_err, dbg_state
  );
endinterface

// File: rtl/udp_tx_framer.sv
// Ethernet II / IPv4 / UDP transmit framer: streams preamble, headers, payload,
// zero pad and CRC-32 FCS one byte at a time, then holds off for the inter-frame gap.
module udp_tx_framer #(
  parameter logic [47:0] FPGA_MAC   = 48'h00_1A_2B_3C_4D_5E,
  parameter logic [31:0] FPGA_IP    = 32'hC0_00_02_92,
  parameter logic [15:0] FPGA_PORT  = 16'd5005,
  parameter logic [7:0]  IP_TTL     = 8'd64,
  parameter int          IFG_CYCLES = 48
) (
  input  logic            clk,
  input  logic            resetn,
  udp_tx_framer_if.master bus
);

  typedef enum logic [3:0] {
    IDLE, CSUM, PREAMBLE, ETH_HEADER, IP_HEADER, UDP_HEADER, PAYLOAD, PAD, FCS, IFG
  } state_t;

  localparam logic [10:0] IFG_LAST = 11'(IFG_CYCLES - 1);

  state_t      state, state_n;
  logic [10:0] cnt, cnt_n;

  logic [10:0] len_q;
  logic [47:0] dmac_q;
  logic [31:0] dip_q;
  logic [15:0] dport_q;
  logic [15:0] ident_q;
  logic [31:0] acc_q;
  logic [31:0] crc_q;
  logic [7:0]  tx_byte_q;
  logic        tx_valid_q;
  logic        busy_q, done_q, err_q;

  logic        load_en, len_ok;
  logic        load, crc_en, last_b, accept, reject, finish, drain, pay_take;
  state_t      nxt;
  logic [7:0]  byte_n;

  logic [15:0]  total_len, udp_len, csum_word, ip_csum, fold2;
  logic [16:0]  fold1;
  logic [159:0] ip_pre, ip_hdr;
  logic [111:0] eth_hdr;
  logic [63:0]  udp_hdr;
  logic [7:0]   eth_byte, ip_byte, udp_byte, fcs_byte;

  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'h0, d};
    for (int i = 0; i < 8; i++) begin
      r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    end
    return r;
  endfunction

  assign len_ok  = (bus.tx_len != 11'd0) && (bus.tx_len <= 11'd1472);
  assign load_en = !tx_valid_q || bus.tx_byte_ready;

  assign total_len = {5'd0, len_q} + 16'd28;
  assign udp_len   = {5'd0, len_q} + 16'd8;

  // The checksum word slot is zero while summing; the folded result replaces it on the wire.
  assign ip_pre  = {16'h4500, total_len, ident_q, 16'h4000, IP_TTL, 8'h11, 16'h0000, FPGA_IP, dip_q};
  assign fold1   = {1'b0, acc_q[31:16]} + {1'b0, acc_q[15:0]};
  assign fold2   = fold1[15:0] + {15'd0, fold1[16]};
  assign ip_csum = ~fold2;
  assign ip_hdr  = {16'h4500, total_len, ident_q, 16'h4000, IP_TTL, 8'h11, ip_csum, FPGA_IP, dip_q};
  assign eth_hdr = {dmac_q, FPGA_MAC, 16'h0800};
  assign udp_hdr = {FPGA_PORT, dport_q, udp_len, 16'h0000};

  assign csum_word = 16'(ip_pre >> {4'd9 - cnt[3:0], 4'd0});
  assign eth_byte  = 8'(eth_hdr >> {4'd13 - cnt[3:0], 3'd0});
  assign ip_byte   = 8'(ip_hdr >> {5'd19 - cnt[4:0], 3'd0});
  assign udp_byte  = 8'(udp_hdr >> {3'd7 - cnt[2:0], 3'd0});
  assign fcs_byte  = 8'((~crc_q) >> {cnt[1:0], 3'd0});

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= IDLE;
      cnt   <= 11'd0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    load     = 1'b0;
    crc_en   = 1'b0;
    last_b   = 1'b0;
    nxt      = state;
    byte_n   = 8'h00;
    accept   = 1'b0;
    reject   = 1'b0;
    finish   = 1'b0;
    drain    = 1'b0;
    pay_take = 1'b0;
    case (state)
      IDLE: begin
        if (bus.tx_start) begin
          if (len_ok) begin
            accept  = 1'b1;
            state_n = CSUM;
            cnt_n   = 11'd0;
          end else begin
            reject = 1'b1;
          end
        end
      end
      CSUM: begin
        if (cnt == 11'd9) begin
          state_n = PREAMBLE;
          cnt_n   = 11'd0;
        end else begin
          cnt_n = cnt + 11'd1;
        end
      end
      PREAMBLE: begin
        load   = load_en;
        byte_n = (cnt == 11'd7) ? 8'hD5 : 8'h55;
        last_b = (cnt == 11'd7);
        nxt    = ETH_HEADER;
      end
      ETH_HEADER: begin
        load   = load_en;
        crc_en = 1'b1;
        byte_n = eth_byte;
        last_b = (cnt == 11'd13);
        nxt    = IP_HEADER;
      end
      IP_HEADER: begin
        load   = load_en;
        crc_en = 1'b1;
        byte_n = ip_byte;
        last_b = (cnt == 11'd19);
        nxt    = UDP_HEADER;
      end
      UDP_HEADER: begin
        load   = load_en;
        crc_en = 1'b1;
        byte_n = udp_byte;
        last_b = (cnt == 11'd7);
        nxt    = PAYLOAD;
      end
      PAYLOAD: begin
        load     = load_en;
        pay_take = load_en;
        crc_en   = 1'b1;
        byte_n   = bus.payload_data;
        last_b   = (cnt == len_q - 11'd1);
        nxt      = (len_q < 11'd18) ? PAD : FCS;
      end
      PAD: begin
        load   = load_en;
        crc_en = 1'b1;
        last_b = (cnt == 11'd17 - len_q);
        nxt    = FCS;
      end
      FCS: begin
        load   = load_en;
        byte_n = fcs_byte;
        last_b = (cnt == 11'd3);
        nxt    = IFG;
      end
      IFG: begin
        // The gap is counted only once the last FCS byte has left the output register.
        if (tx_valid_q) begin
          drain = bus.tx_byte_ready;
        end else if (cnt == IFG_LAST) begin
          state_n = IDLE;
          cnt_n   = 11'd0;
          finish  = 1'b1;
        end else begin
          cnt_n = cnt + 11'd1;
        end
      end
      default: state_n = IDLE;
    endcase
    if (load) begin
      if (last_b) begin
        state_n = nxt;
        cnt_n   = 11'd0;
      end else begin
        cnt_n = cnt + 11'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      len_q      <= 11'd0;
      dmac_q     <= 48'd0;
      dip_q      <= 32'd0;
      dport_q    <= 16'd0;
      ident_q    <= 16'd0;
      acc_q      <= 32'd0;
      crc_q      <= 32'hFFFF_FFFF;
      tx_byte_q  <= 8'h00;
      tx_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      err_q  <= reject;
      done_q <= finish;
      if (accept) begin
        len_q   <= bus.tx_len;
        dmac_q  <= bus.dest_mac;
        dip_q   <= bus.dest_ip;
        dport_q <= bus.dest_port;
        acc_q   <= 32'd0;
        crc_q   <= 32'hFFFF_FFFF;
        busy_q  <= 1'b1;
      end
      if (finish) begin
        busy_q  <= 1'b0;
        ident_q <= ident_q + 16'd1;
      end
      if (state == CSUM) acc_q <= acc_q + {16'd0, csum_word};
      if (load) begin
        tx_byte_q  <= byte_n;
        tx_valid_q <= 1'b1;
        if (crc_en) crc_q <= crc_byte(crc_q, byte_n);
      end else if (drain) begin
        tx_valid_q <= 1'b0;
      end
    end
  end

  assign bus.tx_byte       = tx_byte_q;
  assign bus.tx_byte_valid = tx_valid_q;
  assign bus.payload_ready = pay_take;
  assign bus.tx_busy       = busy_q;
  assign bus.tx_done       = done_q;
  assign bus.tx_err        = err_q;
  assign bus.dbg_state     = state;

endmodule
